// File: rtl/pry2oht_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   DIR_LSB / DIR_MSB : priority direction selectors for pry2oht_tree
//   arb_state_e       : arbiter state (idle / busy)
//   oht2bin           : one-hot vector to binary index
//   msk_above         : one-hot vector to mask of all strictly higher bits
package pry2oht_pkg;

  localparam string DIR_LSB = "LSB";
  localparam string DIR_MSB = "MSB";

  // Widest vector the helper functions accept; callers cast to their width.
  localparam int unsigned MAX_W = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  function automatic int unsigned oht2bin(input logic [MAX_W-1:0] oht);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (oht[i]) b |= i;
    end
    return b;
  endfunction

  // Bits at and below the set bit are (oht | (oht-1)); the rest lie above.
  function automatic logic [MAX_W-1:0] msk_above(input logic [MAX_W-1:0] oht);
    return ~(oht | (oht - MAX_W'(1)));
  endfunction

endpackage

// File: rtl/pry2oht_rrarb_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
//   req : request vector, held high by each requester until released
//   rls : release strobe from the current owner
//   grt : one-hot grant
//   idx : binary index of grt
//   vld : grant active
// master = requester side, slave = arbiter side.
interface pry2oht_rrarb_if #(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req;
  logic                 rls;
  logic [WIDTH-1:0]     grt;
  logic [WIDTH_LOG-1:0] idx;
  logic                 vld;

  modport master (output req, rls, input grt, idx, vld);
  modport slave  (input req, rls, output grt, idx, vld);
endinterface

// File: rtl/pry2oht_tree.sv
// Priority-to-one-hot converter built as a two-level tree: groups of SPLIT
// bits are first reduced, the winning group is chosen, then the winning bit
// inside that group. DIRECTION selects LSB-first or MSB-first priority.
//   din : candidate vector
//   oht : one-hot of the highest-priority set bit (zero when din is zero)
module pry2oht_tree
  import pry2oht_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned SPLIT     = 4,
  parameter string       DIRECTION = DIR_LSB
) (
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] oht
);

  localparam int unsigned NG = (WIDTH + SPLIT - 1) / SPLIT;
  localparam int unsigned PW = NG * SPLIT;

  logic [WIDTH-1:0] vin;
  logic [WIDTH-1:0] vout;
  logic [PW-1:0]    pin;
  logic [PW-1:0]    pout;
  logic [NG-1:0]    gany;
  logic [NG-1:0]    gsel;

  // MSB-first is the LSB-first core with both vectors bit-reversed.
  if (DIRECTION == DIR_MSB) begin : g_msb
    always_comb begin
      vin = '0;
      oht = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        vin[i] = din[WIDTH-1-i];
        oht[i] = vout[WIDTH-1-i];
      end
    end
  end else begin : g_lsb
    assign vin = din;
    assign oht = vout;
  end

  // The running "found/seen" terms gate off every lower-priority bit, so an
  // unknown value above the winner cannot leak into the result.
  always_comb begin
    logic found;
    logic seen;
    pin   = PW'(vin);
    gany  = '0;
    gsel  = '0;
    pout  = '0;
    found = 1'b0;
    for (int unsigned g = 0; g < NG; g++) begin
      gany[g] = |pin[g*SPLIT +: SPLIT];
    end
    for (int unsigned g = 0; g < NG; g++) begin
      gsel[g] = gany[g] & ~found;
      found   = found | gany[g];
    end
    for (int unsigned g = 0; g < NG; g++) begin
      seen = 1'b0;
      for (int unsigned b = 0; b < SPLIT; b++) begin
        pout[g*SPLIT+b] = gsel[g] & pin[g*SPLIT+b] & ~seen;
        seen            = seen | pin[g*SPLIT+b];
      end
    end
    vout = pout[WIDTH-1:0];
  end

endmodule

// File: rtl/pry2oht_rrarb.sv
// Round-robin arbiter sharing one resource among WIDTH requesters. The grant
// is registered, held until the owner releases (rls or request drop), and
// forcibly handed over after MAX_HOLD cycles when others are waiting
// (MAX_HOLD=0 disables the limit). Handover happens in the release edge.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pry2oht_rrarb_if (req, rls in; grt, idx, vld out)
module pry2oht_rrarb
  import pry2oht_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned SPLIT    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  pry2oht_rrarb_if.slave    bus
);

  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);
  localparam int unsigned CNT_W     = ($clog2(MAX_HOLD + 1) > 1) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  arb_state_e           state_q, state_d;
  logic [WIDTH-1:0]     grt_q, grt_d;
  logic [WIDTH_LOG-1:0] idx_q, idx_d;
  logic [WIDTH-1:0]     msk_q, msk_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [WIDTH-1:0]     cnd;
  logic [WIDTH-1:0]     pick_m;
  logic [WIDTH-1:0]     pick_u;
  logic [WIDTH-1:0]     pick;
  logic                 timeout;
  logic                 rel;

  assign cnd  = (state_q == ST_BUSY) ? (bus.req & ~grt_q) : bus.req;
  assign pick = (|pick_m) ? pick_m : pick_u;

  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIR_LSB)) u_tree_msk (
    .din (cnd & msk_q),
    .oht (pick_m)
  );

  pry2oht_tree #(.WIDTH(WIDTH), .SPLIT(SPLIT), .DIRECTION(DIR_LSB)) u_tree_all (
    .din (cnd),
    .oht (pick_u)
  );

  assign timeout = (MAX_HOLD != 0) && (cnt_q == CNT_SAT) && (|cnd);
  assign rel     = bus.rls || !bus.req[idx_q] || timeout;

  always_comb begin
    state_d = state_q;
    grt_d   = grt_q;
    idx_d   = idx_q;
    msk_d   = msk_q;
    cnt_d   = cnt_q;
    // A new grant and a plain release share the same load path: whenever a
    // grant decision is taken and candidates exist, the pick is loaded.
    if ((state_q == ST_IDLE) || rel) begin
      if (|cnd) begin
        state_d = ST_BUSY;
        grt_d   = pick;
        idx_d   = WIDTH_LOG'(oht2bin(MAX_W'(pick)));
        msk_d   = WIDTH'(msk_above(MAX_W'(pick)));
        cnt_d   = '0;
      end else begin
        state_d = ST_IDLE;
        grt_d   = '0;
      end
    end else if (cnt_q != CNT_SAT) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grt_q   <= '0;
      idx_q   <= '0;
      msk_q   <= '1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grt_q   <= grt_d;
      idx_q   <= idx_d;
      msk_q   <= msk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grt = grt_q;
  assign bus.idx = idx_q;
  assign bus.vld = (state_q == ST_BUSY);

endmodule

// File: tb/tb_pry2oht_rrarb.sv
// Self-checking bench for pry2oht_rrarb with WIDTH=4, MAX_HOLD=3.
module tb_pry2oht_rrarb;

  localparam int W        = 4;
  localparam int MAX_HOLD = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pry2oht_rrarb_if #(.WIDTH(W)) bus ();

  pry2oht_rrarb #(.WIDTH(W), .SPLIT(2), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // Reference model: current owner (-1 = none), last granted requester
  // (-1 = none since reset) and number of cycles the owner has held so far.
  int owner = -1;
  int last  = -1;
  int held  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick_next(input logic [W-1:0] c);
    for (int k = 1; k <= W; k++) begin
      int i;
      i = (last + k + W) % W;
      if (c[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    last  = -1;
    held  = 0;
  endtask

  task automatic model_step(input logic [W-1:0] r, input logic rl);
    logic [W-1:0] c;
    bit rel;
    c = r;
    if (owner >= 0) c[owner] = 1'b0;
    if (owner < 0) begin
      rel = 1'b1;
    end else begin
      rel = rl || !r[owner] || (held >= MAX_HOLD && c != 0);
    end
    if (rel) begin
      if (c != 0) begin
        owner = pick_next(c);
        last  = owner;
        held  = 1;
      end else begin
        owner = -1;
      end
    end else begin
      held++;
    end
  endtask

  task automatic check_model(input string tag);
    logic [W-1:0] eg;
    int ei;
    eg = (owner >= 0) ? W'(1 << owner) : '0;
    ei = (owner >= 0) ? owner : ((last < 0) ? 0 : last);
    chk({tag, ".grt"}, 32'(bus.grt), 32'(eg));
    chk({tag, ".idx"}, 32'(bus.idx), 32'(ei));
    chk({tag, ".vld"}, 32'(bus.vld), 32'(owner >= 0));
  endtask

  // Drive inputs, clock once, advance the model, sample 1 time unit later.
  task automatic step(input logic [W-1:0] r, input logic rl, input string tag);
    bus.req = r;
    bus.rls = rl;
    @(posedge clk);
    model_step(r, rl);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    bus.req = '0;
    bus.rls = 1'b0;
    rst_n   = 1'b0;
    model_reset();
    #1;
    chk("rst.grt", 32'(bus.grt), 32'h0);
    chk("rst.vld", 32'(bus.vld), 32'h0);
    chk("rst.idx", 32'(bus.idx), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] rot [5];
  logic [W-1:0] rr;

  initial begin
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = '0;
    bus.rls = 1'b0;

    // Reset state
    do_reset();
    step(4'b0000, 1'b0, "idle");

    // Single request, then release with request dropped
    step(4'b0100, 1'b0, "single");
    chk("single.grt", 32'(bus.grt), 32'h4);
    chk("single.idx", 32'(bus.idx), 32'h2);
    step(4'b0000, 1'b1, "single_rls");
    chk("single_rls.grt", 32'(bus.grt), 32'h0);
    chk("single_rls.vld", 32'(bus.vld), 32'h0);
    chk("single_rls.idx", 32'(bus.idx), 32'h2);

    // Rotation with zero-bubble handover
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, (i != 0), "rot");
      chk("rot.grt", 32'(bus.grt), 32'(rot[i]));
    end

    // Mask wrap: owner idx=2, remaining candidates only below it
    step(4'b1111, 1'b1, "wrap_a");
    step(4'b1111, 1'b1, "wrap_b");
    chk("wrap.idx2", 32'(bus.idx), 32'h2);
    step(4'b0011, 1'b1, "wrap");
    chk("wrap.grt", 32'(bus.grt), 32'h1);

    // Reset mid-grant clears outputs without waiting for a clock edge
    rst_n = 1'b0;
    #1;
    chk("midrst.grt", 32'(bus.grt), 32'h0);
    chk("midrst.vld", 32'(bus.vld), 32'h0);
    chk("midrst.idx", 32'(bus.idx), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Timeout alternation, then a lone requester holds indefinitely
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(4'b0011, 1'b0, "tmo");
      chk("tmo.grt", 32'(bus.grt), (((i / 3) % 2) != 0) ? 32'h2 : 32'h1);
    end
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 1'b0, "alone");
      chk("alone.grt", 32'(bus.grt), 32'h1);
    end

    // rls + owner drop + timeout in the same cycle: one handover only
    do_reset();
    for (int i = 0; i < 3; i++) step(4'b0011, 1'b0, "sim_pre");
    chk("sim_pre.grt", 32'(bus.grt), 32'h1);
    step(4'b0010, 1'b1, "sim");
    chk("sim.grt", 32'(bus.grt), 32'h2);
    step(4'b0010, 1'b0, "sim_hold");
    chk("sim_hold.grt", 32'(bus.grt), 32'h2);
    step(4'b0011, 1'b0, "sim_wait");
    chk("sim_wait.grt", 32'(bus.grt), 32'h2);

    // Exhaustive request/release sweep against the model
    for (int r = 0; r < 16; r++) begin
      for (int l = 0; l < 2; l++) begin
        step(W'(r), l[0], "sweep");
      end
    end

    // Random traffic with occasional asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        rr = W'($urandom);
        step(rr, ($urandom_range(3) == 0), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
